// File: rtl/ula_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : ula_muldiv_if
// Description : Request/response bundle for the iterative multiply/divide unit.
//               Request side : in_valid, in_ready, dataA, dataB, op (funct3).
//               Response side: out_valid, out_ready, out and the flags
//                              Overflow, DivZero, Negative, Zero.
//               master = pipeline side, slave = ula_muldiv.
// Revision    : 1.0 - initial release
// ============================================================================
interface ula_muldiv_if #(
    parameter int N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dataA;
    logic [N-1:0] dataB;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;
    logic         Overflow;
    logic         DivZero;
    logic         Negative;
    logic         Zero;

    modport master (
        output in_valid, dataA, dataB, op, out_ready,
        input  in_ready, out_valid, out, Overflow, DivZero, Negative, Zero
    );

    modport slave (
        input  in_valid, dataA, dataB, op, out_ready,
        output in_ready, out_valid, out, Overflow, DivZero, Negative, Zero
    );
endinterface
`default_nettype wire

// File: rtl/ula_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ula_muldiv
// Description : Iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU,
//               DIV/DIVU/REM/REMU). One radix-2 shift-add or restoring
//               shift-subtract step per cycle; N steps per operation.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - ula_muldiv_if.slave (handshake, operands, result, flags)
// Revision    : 1.0 - initial release
// ============================================================================
module ula_muldiv #(
    parameter int N = 64
) (
    input  logic        clk,
    input  logic        rst,
    ula_muldiv_if.slave bus
);
    localparam int                 c_CNT_W = $clog2(N) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N - 1);
    localparam logic [N-1:0]       c_MIN   = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_op, w_op_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    // Multiply: full product {hi, lo}. Divide: {remainder, quotient}.
    logic [2*N-1:0]     r_acc, w_acc_nxt;
    // Multiplicand for multiply, divisor for divide (magnitude).
    logic [N-1:0]       r_opnd, w_opnd_nxt;
    logic               r_sign_p, w_sign_p_nxt;  // product / quotient sign
    logic               r_sign_a, w_sign_a_nxt;  // dividend sign (remainder)
    logic [N-1:0]       r_out;
    logic               r_ovf, r_dz, r_neg, r_zero;

    logic               w_load;
    logic [N-1:0]       w_res;
    logic               w_ovf, w_dz;

    logic               w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [N-1:0]       w_abs_a, w_abs_b;
    logic [N:0]         w_mul_sum;
    logic [2*N-1:0]     w_mul_step;
    logic [N:0]         w_div_shift, w_div_diff;
    logic [2*N-1:0]     w_div_step;
    logic [2*N-1:0]     w_prod_fix;
    logic [N-1:0]       w_quo_fix, w_rem_fix;

    // Operand conditioning at accept time: MULH treats both operands as
    // signed, MULHSU only dataA, DIV/REM both. MUL's low half is identical
    // for signed and unsigned operands, so it runs unsigned.
    always_comb begin
        w_a_signed = (bus.op == 3'b001) | (bus.op == 3'b010) | (bus.op[2] & ~bus.op[0]);
        w_b_signed = (bus.op == 3'b001) | (bus.op[2] & ~bus.op[0]);
        w_a_neg    = w_a_signed & bus.dataA[N-1];
        w_b_neg    = w_b_signed & bus.dataB[N-1];
        w_abs_a    = w_a_neg ? -bus.dataA : bus.dataA;
        w_abs_b    = w_b_neg ? -bus.dataB : bus.dataB;
    end

    // One iteration of each algorithm, always computed from current state.
    always_comb begin
        // Shift-add: add multiplicand into the high half when the LSB of the
        // multiplier (low half) is set, then shift the 2N+1-bit value right.
        w_mul_sum   = {1'b0, r_acc[2*N-1:N]} + {1'b0, r_opnd};
        w_mul_step  = r_acc[0] ? {w_mul_sum, r_acc[N-1:1]}
                               : {1'b0, r_acc[2*N-1:1]};
        // Restoring divide: shift next dividend bit into the remainder and
        // keep the difference only when it did not borrow.
        w_div_shift = {r_acc[2*N-1:N], r_acc[N-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        w_div_step  = w_div_diff[N] ? {w_div_shift[N-1:0], r_acc[N-2:0], 1'b0}
                                    : {w_div_diff[N-1:0],  r_acc[N-2:0], 1'b1};
        w_prod_fix  = r_sign_p ? -w_mul_step : w_mul_step;
        w_quo_fix   = r_sign_p ? -w_div_step[N-1:0] : w_div_step[N-1:0];
        w_rem_fix   = r_sign_a ? -w_div_step[2*N-1:N] : w_div_step[2*N-1:N];
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_opnd_nxt   = r_opnd;
        w_sign_p_nxt = r_sign_p;
        w_sign_a_nxt = r_sign_a;
        w_load       = 1'b0;
        w_res        = r_out;
        w_ovf        = 1'b0;
        w_dz         = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_op_nxt     = bus.op;
                    w_cnt_nxt    = '0;
                    w_sign_p_nxt = w_a_neg ^ w_b_neg;
                    w_sign_a_nxt = w_a_neg;
                    if (bus.op[2]) begin
                        w_acc_nxt  = {{N{1'b0}}, w_abs_a};
                        w_opnd_nxt = w_abs_b;
                    end else begin
                        w_acc_nxt  = {{N{1'b0}}, w_abs_b};
                        w_opnd_nxt = w_abs_a;
                    end

                    if (bus.op[2] && (bus.dataB == '0)) begin
                        w_load      = 1'b1;
                        w_res       = bus.op[1] ? bus.dataA : '1;
                        w_dz        = 1'b1;
                        w_state_nxt = DONE;
                    end else if (bus.op[2] && !bus.op[0] &&
                                 (bus.dataA == c_MIN) && (bus.dataB == '1)) begin
                        w_load      = 1'b1;
                        w_res       = bus.op[1] ? '0 : bus.dataA;
                        w_ovf       = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = BUSY;
                    end
                end
            end

            BUSY: begin
                w_cnt_nxt = r_cnt + 1'b1;
                w_acc_nxt = r_op[2] ? w_div_step : w_mul_step;
                if (r_cnt == c_LAST) begin
                    w_load      = 1'b1;
                    w_state_nxt = DONE;
                    case (r_op)
                        3'b000:                 w_res = w_prod_fix[N-1:0];
                        3'b001, 3'b010, 3'b011: w_res = w_prod_fix[2*N-1:N];
                        3'b100, 3'b101:         w_res = w_quo_fix;
                        default:                w_res = w_rem_fix;
                    endcase
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_sign_p <= 1'b0;
            r_sign_a <= 1'b0;
            r_out    <= '0;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
            r_neg    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_opnd   <= w_opnd_nxt;
            r_sign_p <= w_sign_p_nxt;
            r_sign_a <= w_sign_a_nxt;
            if (w_load) begin
                r_out  <= w_res;
                r_ovf  <= w_ovf;
                r_dz   <= w_dz;
                r_neg  <= w_res[N-1];
                r_zero <= (w_res == '0);
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out       = r_out;
    assign bus.Overflow  = r_ovf;
    assign bus.DivZero   = r_dz;
    assign bus.Negative  = r_neg;
    assign bus.Zero      = r_zero;
endmodule
`default_nettype wire

// File: tb/tb_ula_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_muldiv
// Description : Directed self-checking bench for ula_muldiv at N=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_muldiv;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ula_muldiv_if #(.N(N)) bus ();

    ula_muldiv #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and wait (bounded) for out_valid.
    // lat counts edges from the accept edge; leak counts cycles in which
    // in_ready was seen high before the result appeared.
    task automatic run_op(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int leak);
        bus.op       = f;
        bus.dataA    = a;
        bus.dataB    = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.dataA    = 8'($urandom);
        bus.dataB    = 8'($urandom);
        lat  = 1;
        leak = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) leak++;
            tick();
            lat++;
        end
        if (bus.in_ready) leak++;
    endtask

    task automatic check_result(input string tag, input logic [7:0] res,
                                input logic ovf, input logic dz);
        check({tag, " out_valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, " out"},       64'(bus.out),       64'(res));
        check({tag, " Overflow"},  64'(bus.Overflow),  64'(ovf));
        check({tag, " DivZero"},   64'(bus.DivZero),   64'(dz));
        check({tag, " Negative"},  64'(bus.Negative),  64'(res[7]));
        check({tag, " Zero"},      64'(bus.Zero),      64'(res == 8'h00));
    endtask

    // Full transaction with out_ready held high: request, latency, result,
    // then one edge to return to IDLE.
    task automatic run_vec(input string tag, input logic [2:0] f, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] res,
                           input logic ovf, input logic dz, input int exp_lat);
        int lat, leak;
        run_op(f, a, b, lat, leak);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " in_ready low"}, 64'(leak), 64'(0));
        check_result(tag, res, ovf, dz);
        tick();
        check({tag, " back to idle"}, 64'(bus.in_ready), 64'(1));
    endtask

    initial begin
        int lat, leak, seen;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dataA     = '0;
        bus.dataB     = '0;
        bus.op        = 3'b000;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("reset out_valid", 64'(bus.out_valid), 64'(0));
        check("reset in_ready",  64'(bus.in_ready),  64'(1));
        check("reset out",       64'(bus.out),       64'(0));
        check("reset flags",     64'({bus.Overflow, bus.DivZero, bus.Negative, bus.Zero}), 64'(0));
        rst = 1'b0;
        tick();
        check("post-reset in_ready", 64'(bus.in_ready), 64'(1));

        // Multiply family
        run_vec("MUL 7*6",     3'b000, 8'h07, 8'h06, 8'h2A, 1'b0, 1'b0, 9);
        run_vec("MULH FE*03",  3'b001, 8'hFE, 8'h03, 8'hFF, 1'b0, 1'b0, 9);
        run_vec("MULHSU FE*03",3'b010, 8'hFE, 8'h03, 8'hFF, 1'b0, 1'b0, 9);
        run_vec("MULHU FE*03", 3'b011, 8'hFE, 8'h03, 8'h02, 1'b0, 1'b0, 9);
        run_vec("MUL FE*03",   3'b000, 8'hFE, 8'h03, 8'hFA, 1'b0, 1'b0, 9);
        run_vec("MULH 80*80",  3'b001, 8'h80, 8'h80, 8'h40, 1'b0, 1'b0, 9);

        // Divide family
        run_vec("DIV F9/02",   3'b100, 8'hF9, 8'h02, 8'hFD, 1'b0, 1'b0, 9);
        run_vec("REM F9/02",   3'b110, 8'hF9, 8'h02, 8'hFF, 1'b0, 1'b0, 9);
        run_vec("DIVU F9/02",  3'b101, 8'hF9, 8'h02, 8'h7C, 1'b0, 1'b0, 9);
        run_vec("REMU F9/02",  3'b111, 8'hF9, 8'h02, 8'h01, 1'b0, 1'b0, 9);
        run_vec("DIV 07/FE",   3'b100, 8'h07, 8'hFE, 8'hFD, 1'b0, 1'b0, 9);

        // Special cases take a single edge
        run_vec("DIV 05/00",   3'b100, 8'h05, 8'h00, 8'hFF, 1'b0, 1'b1, 1);
        run_vec("REMU 05/00",  3'b111, 8'h05, 8'h00, 8'h05, 1'b0, 1'b1, 1);
        run_vec("DIV 80/FF",   3'b100, 8'h80, 8'hFF, 8'h80, 1'b1, 1'b0, 1);
        run_vec("REM 80/FF",   3'b110, 8'h80, 8'hFF, 8'h00, 1'b1, 1'b0, 1);
        run_vec("DIVU 80/FF",  3'b101, 8'h80, 8'hFF, 8'h00, 1'b0, 1'b0, 9);

        // Backpressure: result must hold while out_ready is low
        bus.out_ready = 1'b0;
        run_op(3'b011, 8'hFE, 8'h03, lat, leak);
        check("bp latency", 64'(lat), 64'(9));
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.dataA    = 8'(8'h10 + i);
            bus.op       = 3'b000;
            tick();
            check("bp out_valid held", 64'(bus.out_valid), 64'(1));
            check("bp out held",       64'(bus.out),       64'(8'h02));
            check("bp in_ready low",   64'(bus.in_ready),  64'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp release out_valid", 64'(bus.out_valid), 64'(0));
        check("bp release in_ready",  64'(bus.in_ready),  64'(1));
        check("bp release out kept",  64'(bus.out),       64'(8'h02));
        run_vec("DIVU 64/07 after bp", 3'b101, 8'h64, 8'h07, 8'h0E, 1'b0, 1'b0, 9);

        // Reset while BUSY with counter at 3
        bus.op       = 3'b000;
        bus.dataA    = 8'h0F;
        bus.dataB    = 8'h0F;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("abort accepted", 64'(bus.in_ready), 64'(0));
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort out_valid", 64'(bus.out_valid), 64'(0));
        check("abort out",       64'(bus.out),       64'(0));
        check("abort flags",     64'({bus.Overflow, bus.DivZero, bus.Negative, bus.Zero}), 64'(0));
        check("abort in_ready",  64'(bus.in_ready),  64'(1));
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("aborted result hidden", 64'(seen), 64'(0));
        run_vec("MUL 3*3 after reset", 3'b000, 8'h03, 8'h03, 8'h09, 1'b0, 1'b0, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
